// File: rtl/legv8_pkg.sv
// Shared types and widths for the LEGv8 fetch path.
package legv8_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO of fetch entries with flush; head reads as zero when empty.
module fetch_fifo
  import legv8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [ENTRY_W-1:0]         push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [ENTRY_W-1:0]         head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop, full;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  // a pop frees the head slot, so push+pop is fine even when full
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wrap_inc(wr_q);
      if (do_pop)  rd_q <= wrap_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && !flush_i && full && !do_pop));
endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, credit-limited imem requests, stale-response dropping,
// and a small buffer presenting {pc, instr} to decode.
module fetch_stage
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     inflight_q, inflight_d, drop_q, drop_d;
  logic [CW-1:0]     fifo_cnt, pcq_cnt;
  fetch_entry_t      fifo_head, pcq_head, req_ent, rsp_ent;
  logic              req_fire, rsp_keep, pop;
  logic              unused_pcq;

  // in-flight requests and buffered words share one credit pool
  assign imem_req  = reset_n && !redirect_valid &&
                     (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign req_fire  = imem_req && imem_ready;
  assign pop       = if_valid && if_ready;
  assign rsp_keep  = imem_rvalid && (drop_q == '0) && !redirect_valid;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (req_fire)   pc_d = next_pc(pc_q);
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rvalid);
    drop_d = drop_q;
    // everything still outstanding after this cycle belongs to the old path
    if (redirect_valid)                     drop_d = inflight_d;
    else if (imem_rvalid && drop_q != '0)   drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign req_ent = '{pc: pc_q, instr: '0};
  assign rsp_ent = '{pc: pcq_head.pc, instr: imem_rdata};

  // every response, kept or dropped, retires the oldest request PC
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (req_fire),
    .push_data_i (req_ent),
    .pop_i       (imem_rvalid),
    .flush_i     (1'b0),
    .head_o      (pcq_head),
    .count_o     (pcq_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (rsp_keep),
    .push_data_i (rsp_ent),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  assign if_valid = (fifo_cnt != '0);
  assign if_instr = fifo_head.instr;
  assign if_pc    = fifo_head.pc;

  assign unused_pcq = ^{pcq_head.instr, pcq_cnt};
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with an in-order imem model and an epoch-based
// reference of which fetched words decode must see, and in what order.
module tb_fetch_stage;
  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk, reset_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int errors = 0, checks = 0, cyc = 0;
  int lat_min = 1, lat_rnd = 0, rdy_pct = 100;

  typedef struct { logic [63:0] pc; int epoch; int due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  req_t        q[$];
  req_t        cur;
  ent_t        fm[$];
  logic [63:0] fetch_pc;
  int          epoch = 0, last_due = 0;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return ~a[31:0] ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // imem: in-order responses, one per cycle, never back-pressured
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (!reset_n) begin
      q.delete();
      imem_rvalid = 0;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      cur         = q.pop_front();
      imem_rvalid = 1;
      imem_rdata  = mem_word(cur.pc);
    end else begin
      imem_rvalid = 0;
      imem_rdata  = $urandom;
    end
    imem_ready = ($urandom_range(99) < rdy_pct);
  end

  // reference model and per-cycle comparison, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      int outst, d;
      outst = q.size() + (imem_rvalid ? 1 : 0);
      chk("imem_addr", imem_addr, fetch_pc);
      chk("imem_req", imem_req, (!redirect_valid && (outst + fm.size() < DEPTH)));
      chk("if_valid", if_valid, fm.size() > 0);
      if (fm.size() > 0) begin
        chk("if_pc", if_pc, fm[0].pc);
        chk("if_instr", if_instr, fm[0].instr);
      end
      if (if_valid && if_ready && fm.size() > 0) void'(fm.pop_front());
      if (imem_rvalid && cur.epoch == epoch && !redirect_valid)
        fm.push_back('{cur.pc, mem_word(cur.pc)});
      if (redirect_valid) begin
        fm.delete();
        epoch++;
        fetch_pc = redirect_pc;
      end else if (imem_req && imem_ready) begin
        d = cyc + lat_min + int'($urandom_range(lat_rnd));
        if (d <= last_due) d = last_due + 1;
        q.push_back('{fetch_pc, epoch, d});
        last_due = d;
        fetch_pc = fetch_pc + 64'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n     = 0;
    imem_rvalid = 0;
    q.delete();
    fm.delete();
    epoch++;
    fetch_pc    = RST_PC;
  endtask

  task automatic release_reset();
    last_due = cyc;
    reset_n  = 1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!if_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: no if_valid within 60 cycles, required one", nm);
    end
  endtask

  task automatic redirect_to(input logic [63:0] tgt);
    redirect_valid = 1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    int t0, n;
    reset_n = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    if_ready = 0; redirect_valid = 0; redirect_pc = 0; fetch_pc = RST_PC;
    repeat (3) tick();
    chk("reset imem_req", imem_req, 0);
    chk("reset if_valid", if_valid, 0);
    chk("reset if_instr", if_instr, 0);
    chk("reset if_pc", if_pc, 0);

    // 1: streaming with 1-cycle imem
    if_ready = 1;
    t0 = cyc;
    release_reset();
    wait_valid("t1 first");
    chk("t1 first latency", cyc - t0, 2);
    chk("t1 first pc", if_pc, 64'h0);
    chk("t1 first instr", if_instr, 32'hFFFF_FFFF);
    tick();
    chk("t1 second pc", if_pc, 64'h4);
    chk("t1 second instr", if_instr, 32'hFFFB_FFFB);
    repeat (20) tick();

    // 2: decode stalls, buffer fills, requests stop
    if_ready = 0;
    repeat (6) tick();
    chk("t2 if_valid held", if_valid, 1);
    chk("t2 imem_req off", imem_req, 0);
    chk("t2 outstanding", q.size() + (imem_rvalid ? 1 : 0), 0);
    if_ready = 1;
    repeat (20) tick();

    // 3: 3-cycle imem, redirect with two requests in flight
    lat_min = 3;
    n = 0;
    while ((q.size() + (imem_rvalid ? 1 : 0)) != 2 && n < 40) begin tick(); n++; end
    chk("t3 two in flight", q.size() + (imem_rvalid ? 1 : 0), 2);
    redirect_to(64'h100);
    wait_valid("t3 after redirect");
    chk("t3 pc", if_pc, 64'h100);
    chk("t3 instr", if_instr, 32'hFEFF_FEFF);
    repeat (20) tick();

    // 4: redirect coinciding with a response and a pop
    lat_min = 1;
    n = 0;
    while (!(imem_rvalid && if_valid && if_ready) && n < 40) begin tick(); n++; end
    chk("t4 coincidence found", imem_rvalid && if_valid, 1);
    redirect_to(64'h400);
    wait_valid("t4 after redirect");
    chk("t4 pc", if_pc, 64'h400);
    repeat (10) tick();

    // 5: back-to-back redirects
    redirect_valid = 1;
    redirect_pc    = 64'h200;
    tick();
    redirect_to(64'h300);
    wait_valid("t5 after redirects");
    chk("t5 pc", if_pc, 64'h300);
    repeat (20) tick();

    // random traffic, including a redirect just below the 2^64 wrap
    rdy_pct = 70; lat_rnd = 3;
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(24) == 0);
      if ($urandom_range(2) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
      else                        redirect_pc = {$urandom, $urandom} & ~64'h3;
      tick();
    end
    redirect_valid = 0;

    // 6: asynchronous reset pulse mid-stream
    rdy_pct = 100; lat_rnd = 0; if_ready = 1;
    repeat (10) tick();
    @(posedge clk);
    #4;
    do_reset();
    #1;
    chk("t6 imem_req", imem_req, 0);
    chk("t6 if_valid", if_valid, 0);
    chk("t6 if_instr", if_instr, 0);
    chk("t6 if_pc", if_pc, 0);
    repeat (2) tick();
    release_reset();
    wait_valid("t6 after reset");
    chk("t6 restart pc", if_pc, RST_PC);
    chk("t6 restart instr", if_instr, 32'hFFFF_FFFF);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
